// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial BCD adder/subtractor.
// Optional feature: define BCD_SUB_EN to build subtract support.
package bcd_pkg;

    // One packed BCD digit.
    typedef logic [3:0] bcd_digit_t;

    // Serial operation sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Largest legal digit value and the decimal adjust added on overflow.
    localparam bcd_digit_t BCD_MAX = 4'd9;
    localparam bcd_digit_t BCD_ADJ = 4'd6;

endpackage

// File: rtl/bcd_digit_add.sv
// Combinational single-digit BCD adder with decimal adjust and
// invalid-digit detection.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c,
    output logic [3:0] digit,
    output logic       carry,
    output logic       invalid
);

    logic [4:0] t;

    // Binary sum of the digit pair, then +6 adjust when it passes 9.
    // In subtract mode b arrives as 9-b; that maps 10..15 onto 15..10,
    // so an illegal subtrahend digit is still flagged here.
    always_comb begin
        t       = {1'b0, a} + {1'b0, b} + {4'd0, c};
        digit   = t[3:0];
        carry   = 1'b0;
        invalid = (a > BCD_MAX) || (b > BCD_MAX);
        if (t > {1'b0, BCD_MAX}) begin
            digit = t[3:0] + BCD_ADJ;
            carry = 1'b1;
        end
    end

endmodule

// File: rtl/bcd_serial_addsub.sv
// Digit-serial packed-BCD adder (and optional subtractor).
// Processes one digit per cycle, least significant first.
// Build option: define BCD_SUB_EN to enable ten's-complement subtract;
// otherwise the sub port is ignored and every operation is an add.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; valid must not depend on ready, and data is sampled only on
// that edge. in_ready is high only in IDLE, out_valid only in DONE, and
// the result is held stable in DONE until it is taken.
module bcd_serial_addsub
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  cin,
    input  logic                  sub,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  err
);

    localparam int         W    = 4 * DIGITS;
    localparam logic [4:0] LAST = 5'(DIGITS - 1);

    state_t         state_q, state_n;
    logic [W-1:0]   a_q, b_q, sum_q;
    logic           carry_q, err_q;
    logic [4:0]     idx_q;
    logic           accept;

    logic [3:0]     b_dig;
    logic [3:0]     digit;
    logic           carry;
    logic           invalid;

    assign accept    = in_valid && in_ready;
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = carry_q;
    assign err       = err_q;

`ifdef BCD_SUB_EN
    logic sub_q;

    // Subtract adds the nine's complement of each B digit.
    always_comb begin
        b_dig = b_q[3:0];
        if (sub_q) begin
            b_dig = BCD_MAX - b_q[3:0];
        end
    end
`else
    logic sub_unused;
    assign sub_unused = sub;

    // Add-only build: B digits pass straight through.
    always_comb begin
        b_dig = b_q[3:0];
    end
`endif

    bcd_digit_add u_digit (
        .a       (a_q[3:0]),
        .b       (b_dig),
        .c       (carry_q),
        .digit   (digit),
        .carry   (carry),
        .invalid (invalid)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // Next-state logic: accept, run DIGITS cycles, hold until taken.
    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE: if (accept) state_n = RUN;
            RUN:  if (idx_q == LAST) state_n = DONE;
            DONE: if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Datapath: capture operands on accept, then shift one digit per RUN
    // cycle; result digits enter at the top so digit 0 ends at the bottom.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
`ifdef BCD_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b;
            sum_q   <= '0;
            err_q   <= 1'b0;
            idx_q   <= '0;
`ifdef BCD_SUB_EN
            sub_q   <= sub;
            carry_q <= sub ? ~cin : cin;
`else
            carry_q <= cin;
`endif
        end else if (state_q == RUN) begin
            a_q     <= a_q >> 4;
            b_q     <= b_q >> 4;
            sum_q   <= (sum_q >> 4) | (W'(digit) << (W - 4));
            carry_q <= carry;
            err_q   <= err_q | invalid;
            idx_q   <= idx_q + 5'd1;
        end
    end

endmodule
